// File: rtl/spi_ctrl_param.sv
// spi_ctrl_param: parametrised SPI master (mode 0) for an external SPI memory.
// A frame is: opcode bit (wr), address LSB first, then write data LSB first
// or TURN idle sclk periods followed by DATA_W read bits from miso.
// Every bit lasts 2*CLK_DIV clk cycles: sclk low for CLK_DIV, high for CLK_DIV.
// Optional macro SPI_PARITY_EN appends one odd-parity bit to both frame types.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i, wr_i        transfer request (sampled while idle), 1=write 0=read
//   addr_i, din_i      address / write data, latched with req_i
//   busy_o, done_o     busy from accept through done; one-cycle done pulse
//   err_o              one-cycle pulse with done_o on a failed transfer
//   dout_o             last successful read data
//   cs_o, sclk_o       chip select (active low), serial clock (idles low)
//   mosi_o, miso_i     serial data out / in
module spi_ctrl_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 32,
  parameter int CLK_DIV = 2,
  parameter int TURN    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int B_WR  = 1 + ADDR_W + DATA_W + PAR;
  localparam int B_RD  = 1 + ADDR_W + TURN + DATA_W + PAR;
  localparam int B_MAX = (B_WR > B_RD) ? B_WR : B_RD;
  localparam int BW    = $clog2(B_MAX + 1);
  localparam int PW    = $clog2(2 * CLK_DIV);
  localparam int SRW   = B_WR;
  localparam int RXW   = DATA_W + PAR;

  localparam logic [BW-1:0] LAST_WR  = BW'(B_WR - 1);
  localparam logic [BW-1:0] LAST_RD  = BW'(B_RD - 1);
  localparam logic [BW-1:0] RD_TURN0 = BW'(1 + ADDR_W);
  localparam logic [BW-1:0] RD_DATA0 = BW'(1 + ADDR_W + TURN);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_END   = PW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, SHIFT, TURNA, RDSHIFT, HOLD, DONE, ERROR
  } state_e;

  state_e              state_q, shift_st_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q, dout_q;
  logic [SRW-1:0]      sr_q, frame_d;
  logic [RXW-1:0]      rx_q, rx_d;
  logic [PW-1:0]       ph_q;
  logic [BW-1:0]       bit_q, bit_d;
  logic                busy_q, done_q, err_q, cs_q, sclk_q, mosi_q;
  logic                rd_ok_d;
  logic [31:0]         addr_ext;

  assign addr_ext = 32'(addr_q);

  // Whole outgoing frame, LSB = first bit on the wire. For reads everything
  // past the address is zero, so mosi idles low through turnaround and data.
  always_comb begin
    frame_d            = '0;
    frame_d[0]         = wr_q;
    frame_d[ADDR_W:1]  = addr_q;
    if (wr_q) frame_d[ADDR_W+DATA_W:ADDR_W+1] = din_q;
`ifdef SPI_PARITY_EN
    if (wr_q) frame_d[SRW-1] = ~^{addr_q, din_q};
`endif
  end

  // Read data arrives LSB first: shift in at the top, shift down.
  always_comb begin
    rx_d          = rx_q >> 1;
    rx_d[RXW-1]   = miso_i;
  end

  // State for the bit about to start, chosen by its index in the frame.
  always_comb begin
    bit_d = bit_q + BW'(1);
    if (wr_q || bit_d < RD_TURN0) shift_st_d = SHIFT;
    else if (bit_d < RD_DATA0)    shift_st_d = TURNA;
    else                          shift_st_d = RDSHIFT;
  end

  // Read parity is odd over {addr, data, parity bit}.
`ifdef SPI_PARITY_EN
  assign rd_ok_d = ^{addr_q, rx_q};
`else
  assign rd_ok_d = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      sr_q    <= '0;
      rx_q    <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_i) begin
          wr_q    <= wr_i;
          addr_q  <= addr_i;
          din_q   <= din_i;
          busy_q  <= 1'b1;
          state_q <= CHECK;
        end
        CHECK: begin
          ph_q  <= '0;
          bit_q <= '0;
          if (addr_ext >= 32'(DEPTH)) begin
            state_q <= ERROR;
          end else begin
            state_q <= SHIFT;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= frame_d[0];
            sr_q    <= frame_d >> 1;
          end
        end
        SHIFT, TURNA, RDSHIFT: begin
          ph_q <= ph_q + PW'(1);
          if (ph_q == PH_HALF) begin
            sclk_q <= 1'b1;
            if (state_q == RDSHIFT) rx_q <= rx_d;
          end
          if (ph_q == PH_END) begin
            ph_q   <= '0;
            sclk_q <= 1'b0;
            if (bit_q == (wr_q ? LAST_WR : LAST_RD)) begin
              state_q <= HOLD;
              cs_q    <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              bit_q   <= bit_d;
              mosi_q  <= sr_q[0];
              sr_q    <= sr_q >> 1;
              state_q <= shift_st_d;
            end
          end
        end
        HOLD: begin
          ph_q <= ph_q + PW'(1);
          if (ph_q == PH_HALF) begin
            ph_q    <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!wr_q) begin
              if (rd_ok_d) dout_q <= rx_q[DATA_W-1:0];
              else         err_q  <= 1'b1;
            end
          end
        end
        ERROR: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign dout_o = dout_q;
  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule
